// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: key events -> per-voice key/gate/trigger, retrigger > free > steal oldest.
// Latency: outputs update NUM_VOICES+1 cycles after acceptance (serial scan, then commit).
// Backpressure: ev_ready is low from acceptance until commit, giving one event per NUM_VOICES+2 cycles.
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int KEY_W      = 8,
    parameter int AGE_W      = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ev_valid,
    output logic                                  ev_ready,
    input  logic                                  ev_on,
    input  logic [KEY_W-1:0]                      ev_key,
    output logic [NUM_VOICES*KEY_W-1:0]           voice_key,
    output logic [NUM_VOICES-1:0]                 voice_gate,
    output logic [NUM_VOICES-1:0]                 voice_trigger,
    output logic [$clog2(NUM_VOICES+1)-1:0]       active_count
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(NUM_VOICES+1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]                            state;
    logic [IW-1:0]                         idx;
    logic                                  lat_on;
    logic [KEY_W-1:0]                      lat_key;
    logic                                  match_vld, free_vld, old_vld;
    logic [IW-1:0]                         match_idx, free_idx, old_idx;
    logic [AGE_W-1:0]                      old_age;
    logic [NUM_VOICES-1:0][KEY_W-1:0]      keys;
    logic [NUM_VOICES-1:0][AGE_W-1:0]      ages;
    logic [NUM_VOICES-1:0]                 gates;
    logic [NUM_VOICES-1:0]                 trig;
    logic [CW-1:0]                         cnt;

    logic                                  tgt_vld;
    logic [IW-1:0]                         tgt_idx;
    logic                                  rel_vld;
    logic [NUM_VOICES-1:0]                 gate_nxt;
    logic [CW-1:0]                         cnt_nxt;
    logic                                  cur_gate;
    logic [KEY_W-1:0]                      cur_key;
    logic [AGE_W-1:0]                      cur_age;

    assign ev_ready      = (state == S_IDLE);
    assign voice_key     = keys;
    assign voice_gate    = gates;
    assign voice_trigger = trig;
    assign active_count  = cnt;

    assign cur_gate = gates[idx];
    assign cur_key  = keys[idx];
    assign cur_age  = ages[idx];

    // Commit decision and the next gate vector, so active_count tracks gates on the same edge.
    always_comb begin
        tgt_vld = 1'b0;
        tgt_idx = '0;
        rel_vld = 1'b0;
        if (state == S_COMMIT) begin
            if (lat_on) begin
                tgt_vld = match_vld | free_vld | old_vld;
                if (match_vld)     tgt_idx = match_idx;
                else if (free_vld) tgt_idx = free_idx;
                else               tgt_idx = old_idx;
            end else begin
                rel_vld = match_vld;
            end
        end
        gate_nxt = gates;
        if (tgt_vld) gate_nxt[tgt_idx] = 1'b1;
        if (rel_vld) gate_nxt[match_idx] = 1'b0;
        cnt_nxt = '0;
        for (int i = 0; i < NUM_VOICES; i++) cnt_nxt = cnt_nxt + CW'(gate_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            lat_on    <= 1'b0;
            lat_key   <= '0;
            match_vld <= 1'b0;
            free_vld  <= 1'b0;
            old_vld   <= 1'b0;
            match_idx <= '0;
            free_idx  <= '0;
            old_idx   <= '0;
            old_age   <= '0;
            keys      <= '0;
            ages      <= '0;
            gates     <= '0;
            trig      <= '0;
            cnt       <= '0;
        end else begin
            trig  <= '0;
            gates <= gate_nxt;
            cnt   <= cnt_nxt;
            case (state)
                S_IDLE: begin
                    // Key code 0 means "no key" and is swallowed without a scan.
                    if (ev_valid && ev_key != '0) begin
                        lat_on    <= ev_on;
                        lat_key   <= ev_key;
                        idx       <= '0;
                        match_vld <= 1'b0;
                        free_vld  <= 1'b0;
                        old_vld   <= 1'b0;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!match_vld && cur_gate && cur_key == lat_key) begin
                        match_vld <= 1'b1;
                        match_idx <= idx;
                    end
                    if (!free_vld && !cur_gate) begin
                        free_vld <= 1'b1;
                        free_idx <= idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (cur_gate && (!old_vld || cur_age > old_age)) begin
                        old_vld <= 1'b1;
                        old_idx <= idx;
                        old_age <= cur_age;
                    end
                    idx <= idx + IW'(1);
                    if (idx == IW'(NUM_VOICES-1)) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                    if (tgt_vld) begin
                        keys[tgt_idx] <= lat_key;
                        trig[tgt_idx] <= 1'b1;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IW'(i) == tgt_idx)
                                ages[i] <= '0;
                            else if (gates[i] && ages[i] != {AGE_W{1'b1}})
                                ages[i] <= ages[i] + AGE_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random events against a voice-table model.
module tb_voice_allocator;
    localparam int NV = 8;
    localparam int KW = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ev_valid = 1'b0;
    logic              ev_ready;
    logic              ev_on = 1'b0;
    logic [KW-1:0]     ev_key = '0;
    logic [NV*KW-1:0]  voice_key;
    logic [NV-1:0]     voice_gate;
    logic [NV-1:0]     voice_trigger;
    logic [3:0]        active_count;

    voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_key(ev_key),
        .voice_key(voice_key), .voice_gate(voice_gate),
        .voice_trigger(voice_trigger), .active_count(active_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference voice table
    logic [KW-1:0] m_key [NV];
    bit            m_gate[NV];
    int            m_age [NV];
    logic [NV-1:0] exp_trig;
    int            exp_rl;

    // Observations of the last event
    int               obs_rl;
    logic [NV-1:0]    obs_trig1, obs_trig2, obs_gate;
    logic [NV*KW-1:0] obs_key;
    logic [3:0]       obs_cnt;

    function automatic void model_clear();
        for (int i = 0; i < NV; i++) begin
            m_key[i] = '0; m_gate[i] = 0; m_age[i] = 0;
        end
    endfunction

    function automatic logic [NV*KW-1:0] exp_keys();
        logic [NV*KW-1:0] k;
        for (int i = 0; i < NV; i++) k[i*KW +: KW] = m_key[i];
        return k;
    endfunction

    function automatic logic [NV-1:0] exp_gates();
        logic [NV-1:0] g;
        for (int i = 0; i < NV; i++) g[i] = m_gate[i];
        return g;
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < NV; i++) c += m_gate[i];
        return c;
    endfunction

    function automatic void model_event(bit on, logic [KW-1:0] key);
        int m = -1, f = -1, o = -1, t;
        exp_trig = '0;
        exp_rl = (key == 0) ? 0 : NV + 1;
        if (key == 0) return;
        for (int i = 0; i < NV; i++) begin
            if (m < 0 && m_gate[i] && m_key[i] == key) m = i;
            if (f < 0 && !m_gate[i]) f = i;
            if (m_gate[i] && (o < 0 || m_age[i] > m_age[o])) o = i;
        end
        if (on) begin
            t = (m >= 0) ? m : (f >= 0) ? f : o;
            for (int i = 0; i < NV; i++)
                if (i != t && m_gate[i] && m_age[i] < 255) m_age[i]++;
            m_key[t] = key; m_gate[t] = 1; m_age[t] = 0;
            exp_trig[t] = 1'b1;
        end else if (m >= 0) begin
            m_gate[m] = 0;
        end
    endfunction

    task automatic do_reset();
        ev_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic send_event(bit on, logic [KW-1:0] key);
        int w = 0;
        @(negedge clk);
        while (ev_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 50) begin
            errors++;
            $display("FAIL ready_wait: ev_ready=%b after %0d cycles, required 1", ev_ready, w);
        end
        ev_valid = 1'b1; ev_on = on; ev_key = key;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        ev_on = 1'($urandom);
        ev_key = KW'($urandom);
        obs_rl = 0;
        @(negedge clk);
        while (ev_ready === 1'b0 && obs_rl < 100) begin
            obs_rl++;
            @(negedge clk);
        end
        obs_trig1 = voice_trigger;
        obs_gate  = voice_gate;
        obs_key   = voice_key;
        obs_cnt   = active_count;
        @(negedge clk);
        obs_trig2 = voice_trigger;
        model_event(on, key);
    endtask

    task automatic test_reset();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if (voice_key !== '0 || voice_gate !== '0 || voice_trigger !== '0 || active_count !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: key=%h gate=%h trig=%h cnt=%0d, required all 0",
                         pass, voice_key, voice_gate, voice_trigger, active_count);
            end
            checks++;
            if (ev_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready[%0d]: ev_ready=%b, required 1", pass, ev_ready);
            end
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_single();
        do_reset();
        send_event(1'b1, 8'h15);
        checks++;
        if (obs_rl != 9) begin
            errors++;
            $display("FAIL single_ready_low: got %0d cycles, required 9", obs_rl);
        end
        checks++;
        if (obs_key[7:0] !== 8'h15 || obs_gate !== 8'h01 || obs_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_voice: key0=%h gate=%h cnt=%0d, required 15 01 1", obs_key[7:0], obs_gate, obs_cnt);
        end
        checks++;
        if (obs_trig1 !== 8'h01 || obs_trig2 !== 8'h00) begin
            errors++;
            $display("FAIL single_trigger: %h then %h, required 01 then 00", obs_trig1, obs_trig2);
        end
    endtask

    task automatic test_fill_steal();
        logic [KW-1:0] fill [8] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_event(1'b1, fill[i]);
            checks++;
            if (obs_trig1 !== (8'h01 << i) || obs_key[i*KW +: KW] !== fill[i]) begin
                errors++;
                $display("FAIL fill_voice%0d: trig=%h key=%h, required %h %h",
                         i, obs_trig1, obs_key[i*KW +: KW], 8'h01 << i, fill[i]);
            end
        end
        checks++;
        if (obs_gate !== 8'hFF || obs_cnt !== 4'd8) begin
            errors++;
            $display("FAIL fill_full: gate=%h cnt=%0d, required FF 8", obs_gate, obs_cnt);
        end
        send_event(1'b1, 8'h4A);
        checks++;
        if (obs_key[7:0] !== 8'h4A || obs_trig1 !== 8'h01 || obs_gate !== 8'hFF || obs_key !== exp_keys()) begin
            errors++;
            $display("FAIL steal_oldest: key=%h trig=%h gate=%h, required key=%h trig=01 gate=FF",
                     obs_key, obs_trig1, obs_gate, exp_keys());
        end
    endtask

    task automatic test_release_reuse();
        logic [NV*KW-1:0] k_before;
        send_event(1'b0, 8'h1D);
        checks++;
        if (obs_gate !== 8'hFD || obs_cnt !== 4'd7 || obs_trig1 !== 8'h00 || obs_key[15:8] !== 8'h1D) begin
            errors++;
            $display("FAIL release: gate=%h cnt=%0d trig=%h key1=%h, required FD 7 00 1D",
                     obs_gate, obs_cnt, obs_trig1, obs_key[15:8]);
        end
        send_event(1'b1, 8'h4B);
        checks++;
        if (obs_key[15:8] !== 8'h4B || obs_trig1 !== 8'h02 || obs_gate !== 8'hFF) begin
            errors++;
            $display("FAIL reuse: key1=%h trig=%h gate=%h, required 4B 02 FF", obs_key[15:8], obs_trig1, obs_gate);
        end
        k_before = obs_key;
        send_event(1'b0, 8'h77);
        checks++;
        if (obs_key !== k_before || obs_gate !== 8'hFF || obs_trig1 !== 8'h00 || obs_cnt !== 4'd8) begin
            errors++;
            $display("FAIL release_unheld: key=%h gate=%h trig=%h cnt=%0d, required key=%h FF 00 8",
                     obs_key, obs_gate, obs_trig1, obs_cnt, k_before);
        end
    endtask

    task automatic test_retrigger();
        logic [NV*KW-1:0] k_before = voice_key;
        send_event(1'b1, 8'h24);
        checks++;
        if (obs_trig1 !== 8'h04 || obs_key !== k_before || obs_cnt !== 4'd8) begin
            errors++;
            $display("FAIL retrigger: trig=%h key=%h cnt=%0d, required 04 key=%h 8", obs_trig1, obs_key, obs_cnt, k_before);
        end
        send_event(1'b1, 8'h50);
        checks++;
        if (obs_trig1 === 8'h04 || obs_trig1 !== exp_trig || obs_key !== exp_keys()) begin
            errors++;
            $display("FAIL steal_after_retrigger: trig=%h key=%h, required trig=%h key=%h",
                     obs_trig1, obs_key, exp_trig, exp_keys());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            bit on = ($urandom_range(0, 99) < 65);
            logic [KW-1:0] key = KW'($urandom_range(0, 14));
            send_event(on, key);
            checks++;
            if (obs_rl != exp_rl || obs_trig1 !== exp_trig || obs_trig2 !== '0 || obs_key !== exp_keys() ||
                obs_gate !== exp_gates() || obs_cnt !== 4'(exp_count())) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_ev%0d on=%0d key=%h: rl=%0d trig=%h/%h key=%h gate=%h cnt=%0d, required rl=%0d trig=%h/00 key=%h gate=%h cnt=%0d",
                             n, on, key, obs_rl, obs_trig1, obs_trig2, obs_key, obs_gate, obs_cnt,
                             exp_rl, exp_trig, exp_keys(), exp_gates(), exp_count());
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        while (ev_ready !== 1'b1) @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_key = 8'h15;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (voice_key !== '0 || voice_gate !== '0 || voice_trigger !== '0 || active_count !== '0 || ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: key=%h gate=%h trig=%h cnt=%0d rdy=%b, required all 0 rdy=1",
                     voice_key, voice_gate, voice_trigger, active_count, ev_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        repeat (12) @(negedge clk);
        checks++;
        if (ev_ready !== 1'b1 || voice_gate !== '0 || voice_trigger !== '0) begin
            errors++;
            $display("FAIL reset_mid_discard: rdy=%b gate=%h trig=%h, required 1 00 00", ev_ready, voice_gate, voice_trigger);
        end
        send_event(1'b1, 8'h00);
        checks++;
        if (obs_rl != 0 || obs_gate !== '0 || obs_trig1 !== '0 || obs_key !== '0 || obs_cnt !== '0) begin
            errors++;
            $display("FAIL zero_key: rl=%0d gate=%h trig=%h key=%h cnt=%0d, required 0 00 00 0 0",
                     obs_rl, obs_gate, obs_trig1, obs_key, obs_cnt);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_fill_steal();
        test_release_reuse();
        test_retrigger();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
